// File: rtl/sync_fifo_ff_skip.sv
// Synchronous FIFO ahead of the FF byte-stuffing stage. A skip write stores the entry plus
// one dummy slot, which gives the output stage an extra read cycle.
module sync_fifo_ff_skip #(
    parameter int unsigned DATA_W    = 91,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_MARGIN = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         write_enable,
    input  logic                         rollover_write,
    input  logic [DATA_W-1:0]            write_data,
    input  logic                         read_req,
    input  logic                         err_clr,
    output logic [DATA_W-1:0]            read_data,
    output logic                         rdata_valid,
    output logic                         rdata_dummy,
    output logic                         fifo_empty,
    output logic                         fifo_full,
    output logic                         almost_full,
    output logic [$clog2(DEPTH):0]       fill_count,
    output logic                         overflow_err,
    output logic                         underflow_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // Bit DATA_W of each entry marks a dummy entry from a skip write.
    logic [DATA_W:0] mem [DEPTH];

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   free_c;
    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   wr_addr_next;
    logic [AW-1:0]   rd_addr;
    logic            wr_ok_c;
    logic            rd_ok_c;
    logic            skip_c;

    assign wr_addr      = wr_ptr[AW-1:0];
    assign wr_addr_next = wr_addr + AW'(1);
    assign rd_addr      = rd_ptr[AW-1:0];

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_addr == rd_addr);
    assign fill_count  = wr_ptr - rd_ptr;
    assign free_c      = PW'(DEPTH) - fill_count;
    assign almost_full = (free_c <= PW'(AF_MARGIN));

    // Free space is judged before the edge; a same-cycle read does not help a write.
    always_comb begin
        skip_c  = write_enable && rollover_write;
        wr_ok_c = 1'b0;
        if (write_enable) begin
            wr_ok_c = skip_c ? (free_c >= PW'(2)) : (free_c >= PW'(1));
        end
        rd_ok_c = read_req && !fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem[wr_addr] <= {1'b0, write_data};
            if (skip_c) begin
                mem[wr_addr_next] <= {1'b1, {DATA_W{1'b0}}};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok_c) begin
                wr_ptr <= wr_ptr + (skip_c ? PW'(2) : PW'(1));
            end
            if (rd_ok_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data   <= '0;
            rdata_dummy <= 1'b0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= rd_ok_c;
            if (rd_ok_c) begin
                read_data   <= mem[rd_addr][DATA_W-1:0];
                rdata_dummy <= mem[rd_addr][DATA_W];
            end
        end
    end

    // Clear wins over a same-cycle set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (err_clr) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (write_enable && !wr_ok_c) begin
                overflow_err <= 1'b1;
            end
            if (read_req && fifo_empty) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule
